demux_1xn_stream: RTL and testbench

Registered, flow-controlled 1-to-N stream demultiplexer. It is the parametrised successor of the combinational 1xN demux: it adds a data width, a valid/ready handshake on every port, a per-output holding register, a broadcast mode, and a drop counter for out-of-range selects. It sits between a single producer and NUM_OUT independent consumers that may stall individually.

---
 rtl/demux_1xn_stream.sv | 52 +++++
 tb/tb_demux_1xn_stream.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/demux_1xn_stream.sv
// demux_1xn_stream: registered valid/ready 1-to-N demux with broadcast and a saturating drop counter
module demux_1xn_stream #(
    parameter int NUM_OUT = 8,
    parameter int NUM_SEL = $clog2(NUM_OUT),
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [NUM_SEL-1:0]        in_sel,
    input  logic                      in_bcast,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]          drop_cnt
);
    logic [NUM_OUT-1:0]        v;
    logic [NUM_OUT*DATA_W-1:0] d;
    logic [NUM_OUT-1:0]        hit;
    logic [NUM_OUT-1:0]        free;
    logic [NUM_OUT-1:0]        wr;
    logic                      accept;
    logic                      drop;
    // hit is the target set: all channels on broadcast, none for an out-of-range select
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_OUT; i++)
            hit[i] = in_bcast | ({1'b0, in_sel} == (NUM_SEL+1)'(i));
    end
    assign free      = ~v | out_ready;
    assign in_ready  = in_bcast ? &free : (~|hit | |(hit & free));
    assign accept    = in_valid & in_ready;
    assign wr        = accept ? hit : '0;
    assign drop      = accept & ~|hit;
    assign out_valid = v;
    assign out_data  = d;
    always_ff @(posedge clk) begin
        if (rst) begin
            v        <= '0;
            d        <= '0;
            drop_cnt <= '0;
        end else begin
            v <= (v & ~out_ready) | wr;
            for (int i = 0; i < NUM_OUT; i++)
                if (wr[i]) d[i*DATA_W +: DATA_W] <= in_data;
            if (drop && ~&drop_cnt) drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux_1xn_stream.sv
// tb_demux_1xn_stream: 8-channel and 5-channel instances driven in lockstep against a behavioural model
module tb_demux_1xn_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_bcast;
    logic [7:0]  in_data, req;
    logic [2:0]  in_sel;
    logic [7:0]  ordy8, ov8, dc8;
    logic [63:0] od8;
    logic        ir8;
    logic [4:0]  ordy5, ov5;
    logic [39:0] od5;
    logic [7:0]  dc5;
    logic        ir5;

    int vectors = 0, miscompares = 0;

    logic [7:0] mv [2];
    logic [7:0] md [2][8];
    int         mcnt [2];
    logic       er [2];

    demux_1xn_stream u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(ov8), .out_ready(ordy8),
        .out_data(od8), .drop_cnt(dc8)
    );
    demux_1xn_stream #(.NUM_OUT(5)) u5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir5), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(ov5), .out_ready(ordy5),
        .out_data(od5), .drop_cnt(dc5)
    );

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // A beat is taken if its destination (or every channel, for broadcast) can accept it
    function automatic logic exp_rdy(input int k, input int n, input logic [7:0] ord);
        logic [7:0] fr;
        logic       all_free;
        fr = ~mv[k] | ord;
        all_free = 1'b1;
        for (int i = 0; i < n; i++) all_free &= fr[i];
        if (in_bcast) return all_free;
        if (int'(in_sel) < n) return fr[in_sel];
        return 1'b1;
    endfunction

    task automatic model_edge(input int k, input int n, input logic [7:0] ord, input logic acc);
        if (rst) begin
            mv[k] = '0;
            for (int i = 0; i < 8; i++) md[k][i] = '0;
            mcnt[k] = 0;
            return;
        end
        for (int i = 0; i < n; i++)
            if (acc && (in_bcast || int'(in_sel) == i)) begin
                mv[k][i] = 1'b1;
                md[k][i] = in_data;
            end else if (ord[i]) mv[k][i] = 1'b0;
        if (acc && !in_bcast && int'(in_sel) >= n && mcnt[k] < 255) mcnt[k]++;
    endtask

    task automatic chk_out();
        logic [63:0] e8, e5;
        e8 = '0;
        e5 = '0;
        for (int i = 0; i < 8; i++) e8 |= 64'(md[0][i]) << (8*i);
        for (int i = 0; i < 5; i++) e5 |= 64'(md[1][i]) << (8*i);
        chk("out_valid8", 64'(ov8), 64'(mv[0]));
        chk("out_data8", od8, e8);
        chk("drop_cnt8", 64'(dc8), 64'(mcnt[0]));
        chk("out_valid5", 64'(ov5), 64'(mv[1]));
        chk("out_data5", 64'(od5), e5);
        chk("drop_cnt5", 64'(dc5), 64'(mcnt[1]));
    endtask

    // One clock: consumers only assert ready on channels the model believes are full
    task automatic cyc();
        ordy8 = req & mv[0];
        ordy5 = req[4:0] & mv[1][4:0];
        #1;
        er[0] = exp_rdy(0, 8, ordy8);
        er[1] = exp_rdy(1, 5, {3'b0, ordy5});
        chk("in_ready8", 64'(ir8), 64'(er[0]));
        chk("in_ready5", 64'(ir5), 64'(er[1]));
        @(posedge clk);
        model_edge(0, 8, ordy8, in_valid & er[0]);
        model_edge(1, 5, {3'b0, ordy5}, in_valid & er[1]);
        #1 chk_out();
        @(negedge clk);
    endtask

    task automatic beat(input logic [2:0] s, input logic [7:0] dt, input logic b);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = dt;
        in_bcast = b;
        cyc();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_bcast = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; in_data = '0; in_sel = '0;
        req = '0; ordy8 = '0; ordy5 = '0;
        mv[0] = '0; mv[1] = '0;
        @(negedge clk);
        repeat (2) @(posedge clk);
        model_edge(0, 8, '0, 1'b0);
        model_edge(1, 5, '0, 1'b0);
        #1 chk_out();
        @(negedge clk);
        rst = 1'b0;

        req = 8'hFF;
        for (int s = 0; s < 8; s++) beat(3'(s), 8'hA0 + 8'(s), 1'b0);
        idle();

        req = 8'hF7;
        beat(3, 8'h11, 1'b0);
        beat(3, 8'h22, 1'b0);
        beat(3, 8'h22, 1'b0);
        req = 8'hFF;
        beat(3, 8'h22, 1'b0);
        chk("refill_data", od8[31:24], 8'h22);
        idle();

        req = 8'hFB;
        beat(2, 8'h33, 1'b0);
        beat(5, 8'h55, 1'b0);
        chk("indep_ch2", od8[23:16], 8'h33);
        req = 8'hFF;
        idle();
        idle();

        req = 8'hBF;
        beat(6, 8'h44, 1'b0);
        beat(0, 8'h7E, 1'b1);
        beat(0, 8'h7E, 1'b1);
        req = 8'hFF;
        beat(0, 8'h7E, 1'b1);
        chk("bcast_valid", 64'(ov8), 64'hFF);
        idle();

        for (int j = 0; j < 300; j++) beat(3'(5 + j % 3), 8'(j), 1'b0);
        chk("drop_sat", 64'(dc5), 64'd255);
        idle();

        rst = 1'b1;
        idle();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) beat(7, 8'hD0, 1'b0);
        req = 8'h00;
        for (int s = 0; s < 3; s++) beat(3'(s), 8'hC0 + 8'(s), 1'b0);
        rst = 1'b1;
        beat(3, 8'hEE, 1'b0);
        rst = 1'b0;
        chk("rst_valid", 64'(ov8), 64'h0);

        for (int j = 0; j < 400; j++) begin
            req      = 8'($urandom);
            in_valid = $urandom_range(0, 3) != 0;
            in_sel   = 3'($urandom);
            in_data  = 8'($urandom);
            in_bcast = $urandom_range(0, 7) == 0;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
